// File: rtl/gpu_vram_arbiter.sv
// Single-port VRAM arbiter: GPU read fetch vs. posted CPU writes through a small FIFO.
// The display timing decides who wins; all memory-side signals are registered.
module gpu_vram_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          hvisible,
    input  logic                          vvisible,
    input  logic                          gpu_rd_valid,
    output logic                          gpu_rd_ready,
    input  logic [ADDR_W-1:0]             gpu_rd_addr,
    output logic                          gpu_rdata_valid,
    output logic [DATA_W-1:0]             gpu_rdata,
    input  logic                          cpu_wr_valid,
    output logic                          cpu_wr_ready,
    input  logic [ADDR_W-1:0]             cpu_wr_addr,
    input  logic [DATA_W-1:0]             cpu_wr_data,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          cpu_starved
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_GPU  = 2'd1;
    localparam logic [1:0] GNT_CPU  = 2'd2;

    // FIFO state
    logic [ADDR_W-1:0] fifo_addr_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_empty;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    // Arbitration / pipeline state
    logic [1:0]        grant_sel;
    logic              gpu_idle_hblank;
    logic              gpu_idle_visible;
    logic              active_cpu_slot;

    logic              mem_en_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic              rdata_valid_reg;
    logic              vvisible_d_reg;
    logic              starved_reg;

    assign fifo_empty   = (count_reg == '0);
    assign cpu_wr_ready = (count_reg != CNT_W'(FIFO_DEPTH));
    assign fifo_push    = cpu_wr_valid && cpu_wr_ready;
    assign fifo_pop     = (grant_sel == GNT_CPU);
    assign head_addr    = fifo_addr_mem[rd_ptr_reg];
    assign head_data    = fifo_data_mem[rd_ptr_reg];

    // One write port per entry; only the slot under wr_ptr_reg captures.
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo_entry
            always_ff @(posedge clk) begin
                if (fifo_push && (wr_ptr_reg == PTR_W'(gi))) begin
                    fifo_addr_mem[gi] <= cpu_wr_addr;
                    fifo_data_mem[gi] <= cpu_wr_data;
                end
            end
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        case ({fifo_push, fifo_pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

    // In a visible frame the CPU only gets cycles the GPU leaves idle,
    // whether that idle cycle falls in hblank or inside the visible line.
    assign gpu_idle_hblank  = !hvisible && !gpu_rd_valid;
    assign gpu_idle_visible =  hvisible && !gpu_rd_valid;
    assign active_cpu_slot  = gpu_idle_hblank || gpu_idle_visible;

    always_comb begin
        grant_sel = GNT_NONE;
        if (rst) begin
            grant_sel = GNT_NONE;
        end else if (vvisible) begin
            if (gpu_rd_valid) begin
                grant_sel = GNT_GPU;
            end else if (!fifo_empty && active_cpu_slot) begin
                grant_sel = GNT_CPU;
            end
        end else begin
            if (!fifo_empty) begin
                grant_sel = GNT_CPU;
            end else if (gpu_rd_valid) begin
                grant_sel = GNT_GPU;
            end
        end
    end

    assign gpu_rd_ready = (grant_sel == GNT_GPU);

    // Address and write data hold their last value when nothing is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            mem_en_reg <= (grant_sel != GNT_NONE);
            mem_we_reg <= (grant_sel == GNT_CPU);
            if (grant_sel == GNT_GPU) begin
                mem_addr_reg <= gpu_rd_addr;
            end else if (grant_sel == GNT_CPU) begin
                mem_addr_reg  <= head_addr;
                mem_wdata_reg <= head_data;
            end
        end
    end

    // The macro returns data the cycle after a read enable, so the strobe
    // lines up with mem_rdata directly and the data is passed straight through.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_valid_reg <= 1'b0;
        end else begin
            rdata_valid_reg <= mem_en_reg && !mem_we_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vvisible_d_reg <= 1'b0;
            starved_reg    <= 1'b0;
        end else begin
            vvisible_d_reg <= vvisible;
            if (vvisible_d_reg && !vvisible && !cpu_wr_ready) begin
                starved_reg <= 1'b1;
            end
        end
    end

    assign mem_en          = mem_en_reg;
    assign mem_we          = mem_we_reg;
    assign mem_addr        = mem_addr_reg;
    assign mem_wdata       = mem_wdata_reg;
    assign gpu_rdata_valid = rdata_valid_reg;
    assign gpu_rdata       = rdata_valid_reg ? mem_rdata : '0;
    assign fifo_count      = count_reg;
    assign cpu_starved     = starved_reg;

endmodule
